uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin packet arbiter that shares one unbuffered `uart_tx` transmitter between `N_REQ` byte-stream requesters. Each requester offers bytes with a valid/ready handshake and marks the final byte of a packet with `last`. A grant is held for a whole packet, so packets from different sources never interleave on the serial line. The block sits between the producers and the `uart_tx` `send`/`data`/`busy` interface.

## Interface

**Parameters**
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `DATA_BITS`, default 8: byte width; matches `uart_tx` `DATA_BITS`.
- `GAP_TIMEOUT`, default 1024: idle cycles allowed mid-packet before the grant is revoked; 0 disables the timeout.

**Ports**
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in `N_REQ`: requester i has a byte on offer.
- `req_data` in `N_REQ*DATA_BITS`: byte i is `req_data[i*DATA_BITS +: DATA_BITS]`.
- `req_last` in `N_REQ`: the offered byte is the last byte of its packet.
- `req_ready` out `N_REQ`: byte i is accepted this cycle; at most one bit is set.
- `tx_send` out 1: drives `uart_tx.send`.
- `tx_data` out `DATA_BITS`: drives `uart_tx.data`.
- `tx_busy` in 1: from `uart_tx.busy`.
- `grant` out `N_REQ`: one-hot current owner; all zero when no one owns the transmitter.
- `grant_idx` out `$clog2(N_REQ)`: binary index of the owner; 0 when idle.
- `pkt_abort` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation

**States:** IDLE, GRANT, LAUNCH, DRAIN.

- **IDLE**
  - If any `req_valid` bit is set, pick the first set bit scanning from `(last_idx+1) mod N_REQ` upward with wrap.
  - Register `grant`/`grant_idx` and go to GRANT.
  - `last_idx` resets to `N_REQ-1`, so requester 0 has top priority after reset.
- **GRANT**
  - If `req_valid[g] && !tx_busy`: `tx_send=1`, `tx_data=req_data[g]`, `req_ready[g]=1`; latch `req_last[g]` into `last_q`; clear the gap counter; go to LAUNCH.
  - Otherwise, when `!req_valid[g]`, increment the gap counter.
  - If `GAP_TIMEOUT≠0` and the counter reaches `GAP_TIMEOUT`:
    - pulse `pkt_abort`;
    - set `last_idx=g`;
    - clear `grant`;
    - go to IDLE.
  - While waiting on `tx_busy`, the gap counter holds.
- **LAUNCH**
  - Lasts one cycle, covering the registered rise of `tx_busy`; go to DRAIN unconditionally.
- **DRAIN**
  - Wait for `!tx_busy`.
  - Then, if `last_q`: set `last_idx=g`, clear `grant`, go to IDLE.
  - Else: go to GRANT.
- **Outputs in other states**
  - `tx_send`, `req_ready` and `tx_data` are combinational from state.
  - They are 0 outside the GRANT acceptance cycle.
- **Boundaries**
  - Requests from non-owners are ignored until the owner's packet ends or times out.
  - A single-byte packet (`last` on the first byte) releases the grant after one frame.
  - If `tx_busy` is already high in GRANT, for example because another master drove `uart_tx`, the block waits and does not send.
  - The gap counter saturates at `GAP_TIMEOUT` and uses `$clog2(GAP_TIMEOUT+1)` bits.
- **Reset**
  - `rst_n=0` at any point, including mid-frame, forces IDLE, `grant=0`, `grant_idx=0`, `req_ready=0`, `tx_send=0`, `tx_data=0`, `pkt_abort=0`, gap counter 0, `last_idx=N_REQ-1`.
  - The external `uart_tx` is reset separately and is not sequenced by this block.

## Timing

- **Cycle 0:** a request is seen in IDLE.
- **Cycle 1:** `grant` is valid (GRANT). `tx_send`/`req_ready` are high in the same cycle if `tx_busy=0`.
- **Cycle 2:** LAUNCH; `tx_busy` becomes 1.
- **Cycle ≥3:** DRAIN until `tx_busy` falls.
- **Between bytes of one packet:**
  - `tx_busy` falls at cycle k;
  - GRANT at k+1, with `tx_send` at k+1 if valid;
  - minimum turnaround is 1 cycle after `busy` falls.
- **Between packets:** 2 cycles after `busy` falls (IDLE at k+1, GRANT at k+2).
- **Assertions:**
  - `req_ready` and `tx_send` are never high unless the state is GRANT and `tx_busy=0`.
  - `tx_send` is never high on two consecutive cycles.
  - `$onehot0(grant)` holds always.
- `pkt_abort` is high exactly one cycle, coinciding with the GRANT→IDLE transition edge.

## Test plan

- **Reset priority:** after reset, `req_valid=4'b1010`, each source sends a 1-byte packet → requester 1 is served first (0x11), then requester 3 (0x33).
- **No interleave:** requester 0 sends a 3-byte packet 0xA0,0xA1,0xA2 (`last` on 0xA2) while requester 2 holds valid with 0xC0 → `tx_data` sequence is A0, A1, A2, C0; `grant` stays 4'b0001 for all three frames.
- **Round robin fairness:** all 4 requesters continuously valid with 1-byte packets → grant order 0,1,2,3,0,1; no requester is served twice before the others.
- **Gap timeout:** `GAP_TIMEOUT=16`; requester 2 sends one byte without `last`, then drops valid → `pkt_abort` pulses exactly 16 cycles after the first idle GRANT cycle; next grant goes to requester 3 if valid.
- **External busy:** hold `tx_busy=1` for 50 cycles while requester 0 is granted and valid → no `tx_send`, no `req_ready`, no abort; the byte is sent the first cycle `tx_busy=0`.
- **Reset mid-packet:** assert `rst_n=0` during DRAIN of byte 2 of 4 → next cycle all outputs are 0; after release, requester 0 has top priority again.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one unbuffered uart_tx between N_REQ
// byte-stream requesters. A grant covers a whole packet (up to req_last), so
// packets from different sources never interleave on the serial line. A
// stalled owner loses the grant after GAP_TIMEOUT idle cycles mid-packet.
module uart_tx_arbiter #(
  parameter  int N_REQ       = 4,
  parameter  int DATA_BITS   = 8,
  parameter  int GAP_TIMEOUT = 1024,
  localparam int IDX_W       = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_BITS-1:0] req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_send,
  output logic [DATA_BITS-1:0]       tx_data,
  input  logic                       tx_busy,
  output logic [N_REQ-1:0]           grant,
  output logic [IDX_W-1:0]           grant_idx,
  output logic                       pkt_abort
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_LAUNCH = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  // A zero timeout disables revocation; the counter then stays at 0.
  localparam bit              TIMEOUT_EN = (GAP_TIMEOUT != 0);
  localparam int              GAP_W      = TIMEOUT_EN ? $clog2(GAP_TIMEOUT + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(GAP_TIMEOUT);

  logic [1:0]           state_q;
  logic [IDX_W-1:0]     idx_q;       // current owner, 0 while idle
  logic [IDX_W-1:0]     last_idx_q;  // last owner, round-robin pointer
  logic                 last_q;      // byte in flight ends the packet
  logic [GAP_W-1:0]     gap_q;
  logic                 abort_q;

  logic [DATA_BITS-1:0] req_bytes [N_REQ];
  logic [IDX_W-1:0]     cand;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic                 send_ok;
  logic                 gap_hit;

  // Unpack the flat data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bytes[i] = req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  // Round-robin pick: first valid requester after the previous owner, with wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    cand       = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_idx_q) + k) % N_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Handshake and transmitter drive: only in the GRANT cycle that accepts a byte.
  always_comb begin
    send_ok   = (state_q == ST_GRANT) && req_valid[idx_q] && !tx_busy;
    tx_send   = send_ok;
    tx_data   = send_ok ? req_bytes[idx_q] : '0;
    req_ready = '0;
    if (send_ok) req_ready[idx_q] = 1'b1;
    grant = '0;
    if (state_q != ST_IDLE) grant[idx_q] = 1'b1;
    // Timeout fires on the idle cycle that would bring the count to GAP_TIMEOUT.
    gap_hit = TIMEOUT_EN && (gap_q == GAP_MAX - 1'b1);
  end

  assign grant_idx = idx_q;
  assign pkt_abort = abort_q;

  // Grant state machine, gap counter and abort pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      last_idx_q <= IDX_W'(N_REQ - 1);
      last_q     <= 1'b0;
      gap_q      <= '0;
      abort_q    <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            idx_q   <= pick_idx;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (send_ok) begin
            last_q  <= req_last[idx_q];
            gap_q   <= '0;
            state_q <= ST_LAUNCH;
          end else if (!req_valid[idx_q]) begin
            if (gap_hit) begin
              abort_q    <= 1'b1;
              last_idx_q <= idx_q;
              idx_q      <= '0;
              gap_q      <= '0;
              state_q    <= ST_IDLE;
            end else if (gap_q != GAP_MAX) begin
              gap_q <= gap_q + 1'b1;
            end
          end
          // Valid but transmitter busy: wait with the counter held.
        end
        ST_LAUNCH: begin
          // tx_busy is registered in uart_tx and is not yet high here.
          state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!tx_busy) begin
            if (last_q) begin
              last_idx_q <= idx_q;
              idx_q      <= '0;
              state_q    <= ST_IDLE;
            end else begin
              state_q <= ST_GRANT;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
